// File: rtl/mp_controller.sv
// mp_controller: four-cycle sequencer that decodes an instruction, reads two registers, runs the ALU and writes back
module mp_controller #(
    parameter int CNT_W = 16,
    parameter int AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [AW-1:0]    rf_raddr1,
    output logic [AW-1:0]    rf_raddr2,
    output logic [AW-1:0]    rf_waddr,
    output logic             rf_we,
    output logic [31:0]      rf_wdata,
    output logic [5:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, FAULT} state_t;
    state_t state, nxt;
    logic [5:0] op_q;
    logic [AW-1:0] rs1_q, rs2_q, rd_q;
    logic [31:0] wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic legal, accept, run, unused_bits;
    assign unused_bits = ^instr[31:21];
    assign legal = instr[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                      6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
    assign run = !rst;
    assign accept = run && instr_valid && state == IDLE;
    always_comb begin
        nxt = state == IDLE  ? (accept ? (legal ? READ : FAULT) : IDLE) :
              state == READ  ? EXEC :
              state == EXEC  ? WRITE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= nxt;
            if (accept && legal) begin
                op_q  <= instr[5:0];
                rs1_q <= instr[10:6];
                rs2_q <= instr[15:11];
                rd_q  <= instr[20:16];
            end
            if (state == EXEC) wdata_q <= alu_result;
            if (state == WRITE) cnt_q <= cnt_q + 1'b1;
        end
    end
    // Every output is forced low while rst is asserted, whatever state is mid-flight
    assign instr_ready = run && state == IDLE;
    assign rf_raddr1   = run ? rs1_q : '0;
    assign rf_raddr2   = run ? rs2_q : '0;
    assign rf_waddr    = run ? rd_q : '0;
    assign rf_wdata    = run ? wdata_q : '0;
    assign rf_we       = run && state == WRITE && op_q != 6'h00;
    assign alu_opcode  = (run && state inside {READ, EXEC, WRITE}) ? op_q : 6'h00;
    assign busy        = run && state != IDLE;
    assign done        = run && state == WRITE;
    assign illegal     = run && state == FAULT;
    assign instr_count = run ? cnt_q : '0;
endmodule

// File: tb/tb_mp_controller.sv
// tb_mp_controller: table-driven vectors with a retire scoreboard, plus reset and back-to-back sequences
module tb_mp_controller;
    logic clk = 0, rst = 1, instr_valid = 0, preload = 1;
    logic [31:0] instr = 0, alu_result, rf_wdata;
    logic instr_ready, rf_we, busy, done, illegal;
    logic [4:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [5:0] alu_opcode;
    logic [15:0] instr_count, exp_cnt = 0;
    logic [31:0] regs [32];
    logic [31:0] rd1 = 0, rd2 = 0;
    int cyc = 0, tests = 0, fails = 0;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs1, rs2, rd;
        logic ill, we;
        logic [31:0] wd;
    } vec_t;
    typedef struct {
        logic ill, we;
        logic [4:0] rd;
        logic [31:0] wd;
        int acc;
    } exp_t;
    exp_t sb[$];

    mp_controller dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wdata(rf_wdata), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .busy(busy), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'h02: return a & b;
            6'h03: return a | b;
            6'h04: return a ^ b;
            6'h05: return a + b;
            6'h06: return a << b[4:0];
            6'h07: return a >> b[4:0];
            6'h08: return a - b;
            6'h0A: return {31'd0, $signed(a) < $signed(b)};
            6'h0C: return ~a;
            6'h0D: return 32'd0 - a;
            6'h0F: return a;
            default: return 32'd0;
        endcase
    endfunction

    // Register file with one-cycle read latency feeding a combinational ALU
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            regs[1] <= 32'd7;
            regs[2] <= 32'd5;
        end else if (rf_we) regs[rf_waddr] <= rf_wdata;
        rd1 <= regs[rf_raddr1];
        rd2 <= regs[rf_raddr2];
    end
    assign alu_result = alu(alu_opcode, rd1, rd2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic send(input vec_t v, output int acc);
        int n = 0;
        instr = {11'($urandom_range(0, 2047)), v.rd, v.rs2, v.rs1, v.op};
        instr_valid = 1;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("ready timeout", {31'd0, instr_ready}, 1);
        acc = cyc;
        sb.push_back('{v.ill, v.we, v.rd, v.wd, cyc});
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            exp_cnt = 0;
            sb.delete();
        end else begin
            if (busy) chk("ready low while busy", {31'd0, instr_ready}, 0);
            else chk("instr_count", {16'd0, instr_count}, {16'd0, exp_cnt});
            if (rf_we) chk("rf_we implies done", {31'd0, done}, 1);
            if (done || illegal) begin
                if (sb.size() == 0) chk("unexpected retire", {30'd0, done, illegal}, 0);
                else begin
                    e = sb.pop_front();
                    chk("illegal pulse", {31'd0, illegal}, {31'd0, e.ill});
                    chk("done pulse", {31'd0, done}, {31'd0, !e.ill});
                    chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
                        chk("rf_wdata", rf_wdata, e.wd);
                    end
                    if (illegal) chk("alu_opcode in fault", {26'd0, alu_opcode}, 0);
                    chk("retire latency", cyc - e.acc, e.ill ? 1 : 3);
                    if (done) exp_cnt++;
                end
            end
        end
    end

    initial begin
        vec_t tbl [19];
        int a0, a1, a2, n;
        tbl = '{
            '{6'h05, 5'd1, 5'd2, 5'd3,  1'b0, 1'b1, 32'd12},
            '{6'h08, 5'd2, 5'd1, 5'd1,  1'b0, 1'b1, 32'hFFFFFFFE},
            '{6'h0D, 5'd1, 5'd0, 5'd4,  1'b0, 1'b1, 32'd2},
            '{6'h00, 5'd3, 5'd4, 5'd5,  1'b0, 1'b0, 32'd0},
            '{6'h01, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 32'd0},
            '{6'h3F, 5'd1, 5'd2, 5'd3,  1'b1, 1'b0, 32'd0},
            '{6'h03, 5'd3, 5'd4, 5'd6,  1'b0, 1'b1, 32'd14},
            '{6'h04, 5'd6, 5'd3, 5'd6,  1'b0, 1'b1, 32'd2},
            '{6'h0A, 5'd1, 5'd4, 5'd7,  1'b0, 1'b1, 32'd1},
            '{6'h0B, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 32'd0},
            '{6'h06, 5'd4, 5'd3, 5'd5,  1'b0, 1'b1, 32'h2000},
            '{6'h0F, 5'd5, 5'd0, 5'd2,  1'b0, 1'b1, 32'h2000},
            '{6'h02, 5'd5, 5'd2, 5'd11, 1'b0, 1'b1, 32'h2000},
            '{6'h07, 5'd5, 5'd4, 5'd12, 1'b0, 1'b1, 32'h800},
            '{6'h0C, 5'd7, 5'd0, 5'd13, 1'b0, 1'b1, 32'hFFFFFFFE},
            '{6'h09, 5'd1, 5'd1, 5'd1,  1'b1, 1'b0, 32'd0},
            '{6'h0E, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 32'd0},
            '{6'h10, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 32'd0},
            '{6'h20, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 32'd0}
        };
        repeat (3) @(negedge clk);
        #1 chk("outputs zero in reset", {31'd0, |{instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
            rf_wdata, alu_opcode, busy, done, illegal, instr_count}}, 0);
        @(negedge clk);
        rst = 0;
        preload = 0;
        #1 chk("ready after reset", {31'd0, instr_ready}, 1);
        @(negedge clk);
        foreach (tbl[i]) send(tbl[i], a0);
        instr_valid = 0;
        drain();
        chk("R3", regs[3], 12);
        chk("R6 rd=rs1", regs[6], 2);
        chk("R5 after nop then sll", regs[5], 32'h2000);
        chk("count after table", {16'd0, instr_count}, 12);

        // Reset lands in EXEC of an ADD to R6: the write must be dropped
        instr = {11'h7FF, 5'd6, 5'd4, 5'd3, 6'h05};
        instr_valid = 1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        instr_valid = 0;
        @(negedge clk);
        chk("busy in exec", {31'd0, busy}, 1);
        rst = 1;
        #1 chk("outputs zero mid-instr reset", {31'd0, |{instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
            rf_wdata, alu_opcode, busy, done, illegal, instr_count}}, 0);
        @(negedge clk);
        rst = 0;
        #1 chk("ready after rst drops", {31'd0, instr_ready}, 1);
        chk("count cleared", {16'd0, instr_count}, 0);
        repeat (4) @(negedge clk);
        chk("R6 untouched by dropped add", regs[6], 2);

        // Three ADDs with instr_valid held high
        send('{6'h05, 5'd4, 5'd4, 5'd8, 1'b0, 1'b1, 32'd4}, a0);
        send('{6'h05, 5'd8, 5'd8, 5'd9, 1'b0, 1'b1, 32'd8}, a1);
        send('{6'h05, 5'd9, 5'd9, 5'd10, 1'b0, 1'b1, 32'd16}, a2);
        instr_valid = 0;
        chk("b2b spacing 1", a1 - a0, 4);
        chk("b2b spacing 2", a2 - a1, 4);
        drain();
        chk("count after b2b", {16'd0, instr_count}, 3);
        chk("R10", regs[10], 16);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
